adder_plus_four: RTL and testbench

- PC incrementer for the IF stage of the pipelined CPU: computes next sequential fetch address PC + 4.
- Provides a zero-latency combinational result for the PC-select mux.
- Also provides a registered copy with status flags for the IF/ID boundary and debug.
- Pure datapath block; no hazard or branch logic.

---
 rtl/adder_plus_four.sv | 63 ++++++
 tb/tb_adder_plus_four.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/adder_plus_four.sv
// PC incrementer: pc_in + INCREMENT with carry/alignment flags, plus a registered copy of each.
// Latency: 0 cycles on combinational outputs, 1 cycle on _q outputs; no backpressure, en=0 simply holds the _q state.
module adder_plus_four #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INCREMENT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             en,
    output logic [WIDTH-1:0] pc_plus_four,
    output logic             wrap,
    output logic             misaligned,
    output logic [WIDTH-1:0] pc_plus_four_q,
    output logic             wrap_q,
    output logic             misaligned_q,
    output logic             valid_q
);

    localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INCREMENT);

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] pc_plus_four_d;
    logic             wrap_d;
    logic             misaligned_d;
    logic             valid_d;

    // One extra bit on the sum so the carry-out is the wrap flag.
    always_comb begin
        sum_full     = {1'b0, pc_in} + INC_EXT;
        pc_plus_four = sum_full[WIDTH-1:0];
        wrap         = sum_full[WIDTH];
        misaligned   = (pc_in[1:0] != 2'b00);
    end

    always_comb begin
        pc_plus_four_d = pc_plus_four_q;
        wrap_d         = wrap_q;
        misaligned_d   = misaligned_q;
        valid_d        = valid_q;
        if (en) begin
            pc_plus_four_d = pc_plus_four;
            wrap_d         = wrap;
            misaligned_d   = misaligned;
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_plus_four_q <= '0;
            wrap_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            pc_plus_four_q <= pc_plus_four_d;
            wrap_q         <= wrap_d;
            misaligned_q   <= misaligned_d;
            valid_q        <= valid_d;
        end
    end

endmodule

// File: tb/tb_adder_plus_four.sv
// Bench for adder_plus_four: vector table on the combinational path, scoreboard on the registered path.
module tb_adder_plus_four;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] pc_in;
    logic [W-1:0] pc_plus_four;
    logic         wrap;
    logic         misaligned;
    logic [W-1:0] pc_plus_four_q;
    logic         wrap_q;
    logic         misaligned_q;
    logic         valid_q;

    always #5 clk = ~clk;

    adder_plus_four #(.WIDTH(W), .INCREMENT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .en             (en),
        .pc_plus_four   (pc_plus_four),
        .wrap           (wrap),
        .misaligned     (misaligned),
        .pc_plus_four_q (pc_plus_four_q),
        .wrap_q         (wrap_q),
        .misaligned_q   (misaligned_q),
        .valid_q        (valid_q)
    );

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] sum;
        logic         wrap;
        logic         mis;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         wrap;
        logic         mis;
        logic         vld;
    } reg_t;

    vec_t vecs[7];
    reg_t sb_q[$];
    reg_t model;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_comb(input string name, input logic [W-1:0] s, input logic w, input logic m);
        chk({name, ".sum"},  pc_plus_four, s);
        chk({name, ".wrap"}, {31'b0, wrap}, {31'b0, w});
        chk({name, ".mis"},  {31'b0, misaligned}, {31'b0, m});
    endtask

    // Drive one cycle of inputs, push the reference register state, then compare after the edge.
    task automatic cycle(input string name, input logic r, input logic e, input logic [W-1:0] pc);
        logic [W:0] s;
        reg_t       exp_r;
        rst   = r;
        en    = e;
        pc_in = pc;
        s     = {1'b0, pc} + 33'd4;
        if (r) begin
            model = '{sum: '0, wrap: 1'b0, mis: 1'b0, vld: 1'b0};
        end else if (e) begin
            model = '{sum: s[W-1:0], wrap: s[W], mis: (pc[1:0] != 2'b00), vld: 1'b1};
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        exp_r = sb_q.pop_front();
        chk({name, ".sum_q"},  pc_plus_four_q, exp_r.sum);
        chk({name, ".wrap_q"}, {31'b0, wrap_q}, {31'b0, exp_r.wrap});
        chk({name, ".mis_q"},  {31'b0, misaligned_q}, {31'b0, exp_r.mis});
        chk({name, ".vld_q"},  {31'b0, valid_q}, {31'b0, exp_r.vld});
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0000_0000, sum: 32'h0000_0004, wrap: 1'b0, mis: 1'b0};
        vecs[1] = '{pc: 32'h0000_000F, sum: 32'h0000_0013, wrap: 1'b0, mis: 1'b1};
        vecs[2] = '{pc: 32'hFFFF_FFFC, sum: 32'h0000_0000, wrap: 1'b1, mis: 1'b0};
        vecs[3] = '{pc: 32'hFFFF_FFFF, sum: 32'h0000_0003, wrap: 1'b1, mis: 1'b1};
        vecs[4] = '{pc: 32'hFFFF_FFFB, sum: 32'hFFFF_FFFF, wrap: 1'b0, mis: 1'b1};
        vecs[5] = '{pc: 32'h0000_0100, sum: 32'h0000_0104, wrap: 1'b0, mis: 1'b0};
        vecs[6] = '{pc: 32'h7FFF_FFFE, sum: 32'h8000_0002, wrap: 1'b0, mis: 1'b1};
        model   = '{sum: '0, wrap: 1'b0, mis: 1'b0, vld: 1'b0};

        rst   = 1'b1;
        en    = 1'b0;
        pc_in = 32'h0;

        // Combinational path, including a swap after 500 ns.
        #1;
        chk_comb("comb_zero", 32'h4, 1'b0, 1'b0);
        pc_in = 32'hF;
        #1;
        chk_comb("comb_fifteen", 32'h13, 1'b0, 1'b1);
        #500;
        pc_in = 32'h0;
        #1;
        chk_comb("comb_swap", 32'h4, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            pc_in = vecs[i].pc;
            #1;
            chk_comb($sformatf("vec%0d", i), vecs[i].sum, vecs[i].wrap, vecs[i].mis);
        end

        // Registered path.
        @(negedge clk);
        cycle("reset", 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            cycle($sformatf("reg_vec%0d", i), 1'b0, 1'b1, vecs[i].pc);
        end
        cycle("load_100", 1'b0, 1'b1, 32'h100);
        cycle("hold_a", 1'b0, 1'b0, 32'h200);
        chk_comb("comb_during_hold", 32'h204, 1'b0, 1'b0);
        cycle("hold_b", 1'b0, 1'b0, 32'hFFFF_FFFF);
        cycle("rst_over_en", 1'b1, 1'b1, 32'h300);
        chk_comb("comb_during_rst", 32'h304, 1'b0, 1'b0);
        cycle("post_rst_hold", 1'b0, 1'b0, 32'h400);
        cycle("reload", 1'b0, 1'b1, 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
